mips_bus_arbiter: RTL
=====================

MIPS_BUS_ARBITER -- requirements
Module: mips_bus_arbiter

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 255, waitrequest cycles tolerated per transfer before forced completion (1..65535).
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: i_address  input  32, i_read  input  1, i_waitrequest  output  1, i_readdata  output  32  (instruction-fetch requester, read-only).
REQ-005 SHALL have ports: d_address  input  32, d_read  input  1, d_write  input  1, d_writedata  input  32, d_byteenable  input  4, d_waitrequest  output  1, d_readdata  output  32  (data requester).
REQ-006 SHALL have ports: address  output  32, read  output  1, write  output  1, writedata  output  32, byteenable  output  4, waitrequest  input  1, readdata  input  32  (shared Avalon master to memory).
REQ-007 SHALL have ports: grant  output  2  one-hot {data,instr}, busy  output  1  transfer in progress, err  output  2  sticky {protocol,timeout}.

Function
REQ-008 SHALL implement FSM states IDLE, GRANT_I, GRANT_D.
REQ-009 A requester is pending when i_read=1 (instr), or exactly one of d_read/d_write=1 (data).
REQ-010 IDLE: one pending -> grant it next cycle; none -> stay IDLE.
REQ-011 Both pending -> grant the one not served last (last_grant register); last_grant resets to instr, so data wins the first tie.
REQ-012 In GRANT_x, master address/read/write/writedata/byteenable SHALL combinationally mirror requester x; in IDLE, read=write=0, byteenable=0, address=writedata=0.
REQ-013 Arbitration latency: request seen in IDLE at edge N -> master read/write asserted in cycle N+1.
REQ-014 Transfer completes in a granted cycle with (read|write)=1 and waitrequest=0; x_waitrequest=0 for exactly that cycle.
REQ-015 x_waitrequest SHALL be 1 in every other cycle, including ungranted and idle cycles.
REQ-016 i_readdata and d_readdata SHALL both equal readdata (broadcast); valid only on the completing cycle.
REQ-017 On completion, last_grant updates; if the other requester is pending, grant switches directly (no IDLE cycle), else return to IDLE.
REQ-018 If the granted requester deasserts its request before completion: abort, return to IDLE next cycle, set err[1].
REQ-019 d_read=d_write=1 simultaneously: data port not pending, never granted; err[1] set; instr port unaffected.
REQ-020 Timeout counter clears on grant, increments each granted cycle with waitrequest=1. At TIMEOUT_CYCLES: force completion (x_waitrequest=0, x_readdata=0), set err[0], deassert master, go to IDLE.
REQ-021 busy=1 in GRANT_I/GRANT_D; grant reflects state (01 instr, 10 data, 00 IDLE).
REQ-022 err bits SHALL be sticky until reset.

Reset
REQ-023 reset=0 SHALL asynchronously force: IDLE, last_grant=instr, counter=0, err=00, grant=00, busy=0, read=write=0.
REQ-024 Reset mid-transfer SHALL immediately deassert read/write; the transfer is abandoned without a completion pulse.
REQ-025 First grant possible on the first rising edge after reset deasserts.

Structure
REQ-026 The arb_state_t enum and the requester index constants SHALL live in the shared mips_cpu_definitions package.
REQ-027 The timeout counter SHALL be one sub-module, mips_bus_timeout (inputs: clear, count enable; output: expired).

Verification
REQ-028 i_read=1 @0xBFC00000, waitrequest=0 -> read=1 and address=0xBFC00000 next cycle; i_waitrequest=0 that cycle, i_readdata=readdata.
REQ-029 Both requesters pending from reset -> data served first, then instr with no IDLE gap; grant 10 then 01.
REQ-030 d_write 0x12345678, be=0011, waitrequest high 3 cycles -> write held 4 cycles, d_waitrequest=0 only on cycle 4, i_read waits.
REQ-031 TIMEOUT_CYCLES=4, waitrequest stuck 1 -> forced completion after 4 cycles, d_readdata=0, err=01, FSM IDLE.
REQ-032 d_read=d_write=1 -> no grant to data, err=10; concurrent i_read still served.
REQ-033 reset=0 asserted mid-wait -> read/write drop without a clock edge; all outputs at reset values.

Source files
------------

// File: rtl/mips_cpu_definitions.sv
// Shared definitions for the MIPS CPU bus fabric: arbiter states, requester
// indices and the width of the transfer timeout counter.
package mips_cpu_definitions;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_t;

  // Requester indices, also the bit positions inside the grant vector.
  localparam logic [0:0] REQ_INSTR = 1'b0;
  localparam logic [0:0] REQ_DATA  = 1'b1;

  localparam int unsigned TIMEOUT_WIDTH = 16;

endpackage

// File: rtl/mips_bus_timeout.sv
// Counts waitrequest cycles of the current transfer and flags when the
// tolerated number of stalled cycles has been reached.
module mips_bus_timeout
  import mips_cpu_definitions::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic count_en_i,
  output logic expired_o
);

  localparam logic [TIMEOUT_WIDTH-1:0] LIMIT = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);

  logic [TIMEOUT_WIDTH-1:0] count_q, count_d;

  assign expired_o = (count_q == LIMIT);

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (count_en_i && !expired_o) begin
      count_d = count_q + TIMEOUT_WIDTH'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, matching real hardware.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mips_bus_arbiter.sv
// Two-port arbiter sharing one Avalon master between the instruction-fetch
// and data requesters, with alternating tie-break, abort and timeout handling.
module mips_bus_arbiter
  import mips_cpu_definitions::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  // instruction-fetch requester
  input  logic [31:0] i_address,
  input  logic        i_read,
  output logic        i_waitrequest,
  output logic [31:0] i_readdata,
  // data requester
  input  logic [31:0] d_address,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_writedata,
  input  logic [3:0]  d_byteenable,
  output logic        d_waitrequest,
  output logic [31:0] d_readdata,
  // shared master
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  // status
  output logic [1:0]  grant,
  output logic        busy,
  output logic [1:0]  err
);

  arb_state_t state_q, state_d;
  logic [0:0] last_grant_q, last_grant_d;
  logic [1:0] err_q, err_d;

  logic i_pend, d_pend;
  logic expired, done, forced, abort;
  logic count_en, count_clear;

  // A data request with both strobes set is malformed and never pending.
  assign i_pend = i_read;
  assign d_pend = d_read ^ d_write;

  // NOTE: every signal driven here receives a default first, so no path
  // through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    address       = '0;
    read          = 1'b0;
    write         = 1'b0;
    writedata     = '0;
    byteenable    = '0;
    i_waitrequest = 1'b1;
    d_waitrequest = 1'b1;
    done          = 1'b0;
    forced        = 1'b0;
    abort         = 1'b0;

    case (state_q)
      IDLE: begin
        if (d_pend && (!i_pend || last_grant_q == REQ_INSTR)) begin
          state_d = GRANT_D;
        end else if (i_pend) begin
          state_d = GRANT_I;
        end
      end

      GRANT_I: begin
        address = i_address;
        read    = i_read;
        if (expired) begin
          read          = 1'b0;
          i_waitrequest = 1'b0;
          forced        = 1'b1;
          last_grant_d  = REQ_INSTR;
          state_d       = IDLE;
        end else if (!i_pend) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else if (!waitrequest) begin
          i_waitrequest = 1'b0;
          done          = 1'b1;
          last_grant_d  = REQ_INSTR;
          state_d       = d_pend ? GRANT_D : IDLE;
        end
      end

      GRANT_D: begin
        address    = d_address;
        read       = d_read;
        write      = d_write;
        writedata  = d_writedata;
        byteenable = d_byteenable;
        if (expired) begin
          read          = 1'b0;
          write         = 1'b0;
          d_waitrequest = 1'b0;
          forced        = 1'b1;
          last_grant_d  = REQ_DATA;
          state_d       = IDLE;
        end else if (!d_pend) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else if (!waitrequest) begin
          d_waitrequest = 1'b0;
          done          = 1'b1;
          last_grant_d  = REQ_DATA;
          state_d       = i_pend ? GRANT_I : IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Every grant ends with a state change, so that edge restarts the count.
  assign count_clear = (state_d != state_q);
  assign count_en    = waitrequest &&
                       ((state_q == GRANT_I && i_pend) ||
                        (state_q == GRANT_D && d_pend));

  mips_bus_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .rst_n     (reset),
    .clear_i   (count_clear),
    .count_en_i(count_en),
    .expired_o (expired)
  );

  assign err_d = err_q | {abort | (d_read & d_write), forced};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= REQ_INSTR;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
    end
  end

  // A forced completion hands back zero rather than whatever the bus shows.
  assign i_readdata = forced ? '0 : readdata;
  assign d_readdata = forced ? '0 : readdata;

  assign grant[REQ_INSTR] = (state_q == GRANT_I);
  assign grant[REQ_DATA]  = (state_q == GRANT_D);
  assign busy             = (state_q != IDLE);
  assign err              = err_q;

endmodule
